// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner.
// Segment codes are gfedcba, bit 0 = segment a, all active-high.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b1111100;
    localparam logic [6:0] SEG_C     = 7'b0111001;
    localparam logic [6:0] SEG_D     = 7'b1011110;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_F     = 7'b1110001;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Width of a counter/index covering 0..n-1, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_scan_seg_decoder.sv
// Combinational nibble to 7-segment (gfedcba) decoder.
// Optional feature macro: DISPLAY_SCAN_HEX_EN -- when defined, 10..15 show
// A b C d E F; when undefined they decode to blank.
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Segments
);

    // Table lookup; anything not listed falls back to a dark digit.
    always_comb begin
        o_Segments = SEG_BLANK;
        case (i_Nibble)
            4'h0:    o_Segments = SEG_0;
            4'h1:    o_Segments = SEG_1;
            4'h2:    o_Segments = SEG_2;
            4'h3:    o_Segments = SEG_3;
            4'h4:    o_Segments = SEG_4;
            4'h5:    o_Segments = SEG_5;
            4'h6:    o_Segments = SEG_6;
            4'h7:    o_Segments = SEG_7;
            4'h8:    o_Segments = SEG_8;
            4'h9:    o_Segments = SEG_9;
`ifdef DISPLAY_SCAN_HEX_EN
            4'hA:    o_Segments = SEG_A;
            4'hB:    o_Segments = SEG_B;
            4'hC:    o_Segments = SEG_C;
            4'hD:    o_Segments = SEG_D;
            4'hE:    o_Segments = SEG_E;
            4'hF:    o_Segments = SEG_F;
`else
            default: o_Segments = SEG_BLANK;
`endif
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Multiplexed 7-segment display scanner with blank time, PWM brightness,
// per-digit dots and once-per-frame data latching.
// Optional feature macro: DISPLAY_SCAN_HEX_EN (see seg_decoder).
module display_scan
    import display_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic                             i_Clk,
    input  logic                             i_Reset,
    input  logic [4*DIGITS-1:0]              i_Data,
    input  logic [DIGITS-1:0]                i_Enable_Digits,
    input  logic [DIGITS-1:0]                i_Dots,
    input  logic [3:0]                       i_Brightness,
    output logic [7:0]                       o_Segments,
    output logic [DIGITS-1:0]                o_Digits,
    output logic [idxWidth(DIGITS)-1:0]      o_Scan_Index,
    output logic                             o_Frame_Start
);

    localparam int                IDX_W     = idxWidth(DIGITS);
    localparam int                PRE_W     = idxWidth(SCAN_DIV);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [PRE_W-1:0]  LAST_PRE  = PRE_W'(SCAN_DIV - 1);
    localparam logic [PRE_W-1:0]  BLANK_END = PRE_W'(BLANK_CYCLES);
    localparam logic [7:0]        SEG_INV   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] DIG_INV   = {DIGITS{DIG_ACTIVE_LOW}};

    logic [PRE_W-1:0]    r_prescaler;
    logic [IDX_W-1:0]    r_index;
    logic [3:0]          r_pwm;
    logic [4*DIGITS-1:0] r_shadowData;
    logic [DIGITS-1:0]   r_shadowEn;
    logic [DIGITS-1:0]   r_shadowDots;

    logic                w_frameEvent;
    logic [4*DIGITS-1:0] w_shadowDataNext;
    logic [DIGITS-1:0]   w_shadowEnNext;
    logic [DIGITS-1:0]   w_shadowDotsNext;
    logic [3:0]          w_nibble;
    logic [6:0]          w_decoded;
    logic [DIGITS-1:0]   w_strobe;

    // The output stage looks at the shadow values as they will be after this
    // edge, so the frame pulse and the freshly latched data reach the pins together.
    always_comb begin
        w_frameEvent     = (r_prescaler == '0) && (r_index == '0);
        w_shadowDataNext = w_frameEvent ? i_Data          : r_shadowData;
        w_shadowEnNext   = w_frameEvent ? i_Enable_Digits : r_shadowEn;
        w_shadowDotsNext = w_frameEvent ? i_Dots          : r_shadowDots;
        w_nibble         = w_shadowDataNext[{r_index, 2'b00} +: 4];
    end

    seg_decoder u_segDecoder (
        .i_Nibble   (w_nibble),
        .o_Segments (w_decoded)
    );

    // Light the current digit only past the blank window, when enabled and in the PWM on-phase.
    always_comb begin
        w_strobe = '0;
        if ((r_prescaler >= BLANK_END) && w_shadowEnNext[r_index] && (r_pwm <= i_Brightness)) begin
            w_strobe[r_index] = 1'b1;
        end
    end

    // Scan timing, PWM phase and the frame-stable shadow copies of the inputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_prescaler  <= '0;
            r_index      <= '0;
            r_pwm        <= '0;
            r_shadowData <= '0;
            r_shadowEn   <= '0;
            r_shadowDots <= '0;
        end else begin
            r_pwm <= r_pwm + 4'd1;
            if (r_prescaler == LAST_PRE) begin
                r_prescaler <= '0;
                r_index     <= (r_index == LAST_IDX) ? '0 : r_index + 1'b1;
            end else begin
                r_prescaler <= r_prescaler + 1'b1;
            end
            r_shadowData <= w_shadowDataNext;
            r_shadowEn   <= w_shadowEnNext;
            r_shadowDots <= w_shadowDotsNext;
        end
    end

    // Pin registers with board polarity folded in; reset drives everything dark.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Segments    <= SEG_INV;
            o_Digits      <= DIG_INV;
            o_Scan_Index  <= '0;
            o_Frame_Start <= 1'b0;
        end else begin
            o_Segments    <= {w_shadowDotsNext[r_index], w_decoded} ^ SEG_INV;
            o_Digits      <= w_strobe ^ DIG_INV;
            o_Scan_Index  <= r_index;
            o_Frame_Start <= w_frameEvent;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: a time-based reference model pushes
// the expected pin state each cycle and it is compared after the edge.
module tb_display_scan;

    localparam int DIGITS    = 4;
    localparam int SCAN_DIV  = 8;
    localparam int BLANK     = 2;
    localparam bit SEG_AL    = 1'b1;
    localparam bit DIG_AL    = 1'b0;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    typedef struct packed {
        logic [DIGITS-1:0] digits;
        logic [7:0]        segments;
        logic [1:0]        index;
        logic              frameStart;
    } expT;

    logic                clk = 1'b0;
    logic                rst;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   enables;
    logic [DIGITS-1:0]   dots;
    logic [3:0]          bright;
    logic [7:0]          segOut;
    logic [DIGITS-1:0]   digOut;
    logic [1:0]          idxOut;
    logic                fsOut;

    int assertCount = 0;
    int failCount   = 0;
    int t           = 0;
    int fsSeen      = 0;
    logic [4*DIGITS-1:0] shData;
    logic [DIGITS-1:0]   shEn;
    logic [DIGITS-1:0]   shDots;
    expT                 expQ[$];

    display_scan #(
        .DIGITS         (DIGITS),
        .SCAN_DIV       (SCAN_DIV),
        .BLANK_CYCLES   (BLANK),
        .SEG_ACTIVE_LOW (SEG_AL),
        .DIG_ACTIVE_LOW (DIG_AL)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_Data          (data),
        .i_Enable_Digits (enables),
        .i_Dots          (dots),
        .i_Brightness    (bright),
        .o_Segments      (segOut),
        .o_Digits        (digOut),
        .o_Scan_Index    (idxOut),
        .o_Frame_Start   (fsOut)
    );

    always #5 clk = ~clk;

    // Independent decode table for the model.
    function automatic logic [6:0] refDecode(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0111111;
            4'h1: return 7'b0000110;
            4'h2: return 7'b1011011;
            4'h3: return 7'b1001111;
            4'h4: return 7'b1100110;
            4'h5: return 7'b1101101;
            4'h6: return 7'b1111101;
            4'h7: return 7'b0000111;
            4'h8: return 7'b1111111;
            4'h9: return 7'b1101111;
`ifdef DISPLAY_SCAN_HEX_EN
            4'hA: return 7'b1110111;
            4'hB: return 7'b1111100;
            4'hC: return 7'b0111001;
            4'hD: return 7'b1011110;
            4'hE: return 7'b1111001;
            4'hF: return 7'b1110001;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at t=%0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Run n cycles: predict the pins for the coming edge, then compare after it.
    task automatic applyStimulus(input int n);
        expT e;
        expT got;
        int  pre;
        int  slot;
        for (int c = 0; c < n; c++) begin
            if (rst) begin
                e.digits     = DIG_AL ? '1 : '0;
                e.segments   = SEG_AL ? 8'hFF : 8'h00;
                e.index      = 2'd0;
                e.frameStart = 1'b0;
                shData = '0; shEn = '0; shDots = '0;
            end else begin
                pre  = t % SCAN_DIV;
                slot = (t / SCAN_DIV) % DIGITS;
                e.frameStart = ((t % FRAME) == 0);
                if (e.frameStart) begin
                    shData = data; shEn = enables; shDots = dots;
                end
                e.digits = '0;
                if (pre >= BLANK && shEn[slot] && (t % 16) <= int'(bright))
                    e.digits[slot] = 1'b1;
                if (DIG_AL) e.digits = ~e.digits;
                e.segments = {shDots[slot], refDecode(shData[slot*4 +: 4])};
                if (SEG_AL) e.segments = ~e.segments;
                e.index = 2'(slot);
            end
            expQ.push_back(e);
            @(posedge clk);
            #1;
            t = rst ? 0 : t + 1;
            got = expQ.pop_front();
            checkOutput("digits", 32'(digOut), 32'(got.digits));
            checkOutput("segments", 32'(segOut), 32'(got.segments));
            checkOutput("scanIndex", 32'(idxOut), 32'(got.index));
            checkOutput("frameStart", 32'(fsOut), 32'(got.frameStart));
            checkOutput("oneHot", 32'($countones(digOut ^ {DIGITS{DIG_AL}}) <= 1), 32'd1);
            if (fsOut) fsSeen++;
        end
    endtask

    // Advance until the model sits at the given cycle-of-frame.
    task automatic runToFramePos(input int pos);
        for (int k = 0; k < 2 * FRAME && (t % FRAME) != pos; k++)
            applyStimulus(1);
    endtask

    initial begin
        int fsBase;
        rst = 1'b1; data = 16'h4321; enables = 4'b1111; dots = 4'b0000; bright = 4'd15;
        shData = '0; shEn = '0; shDots = '0;
        applyStimulus(3);
        $display("[TB] basic scan");
        rst = 1'b0;
        fsBase = fsSeen;
        applyStimulus(3 * FRAME);
        checkOutput("framePulses", 32'(fsSeen - fsBase), 32'd3);

        $display("[TB] data tearing");
        runToFramePos(10);
        data = 16'h9999;
        applyStimulus(FRAME + 8);
        data = 16'h4321;

        $display("[TB] brightness");
        bright = 4'd0;
        applyStimulus(2 * FRAME);
        bright = 4'd7;
        applyStimulus(2 * FRAME);
        bright = 4'd15;

        $display("[TB] enable and dots");
        enables = 4'b0101; dots = 4'b0010;
        applyStimulus(2 * FRAME);
        enables = 4'b1111; dots = 4'b0000;

        $display("[TB] hex nibbles");
        data = 16'hFEDA;
        applyStimulus(2 * FRAME);
        data = 16'hCB87;
        applyStimulus(FRAME);

        $display("[TB] reset mid-slot");
        data = 16'h5601;
        runToFramePos(2 * SCAN_DIV + 5);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        fsBase = fsSeen;
        applyStimulus(2);
        checkOutput("frameAfterReset", 32'(fsSeen - fsBase), 32'd1);
        applyStimulus(FRAME);

        $display("[TB] random traffic");
        for (int r = 0; r < 12; r++) begin
            data    = 16'($urandom);
            enables = 4'($urandom);
            dots    = 4'($urandom);
            bright  = 4'($urandom_range(0, 15));
            applyStimulus(int'($urandom_range(5, 40)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
